// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the skid-buffered pipeline stage.
//   pipe_state_e : stage state (EMPTY = nothing held, BUSY = main entry only,
//                  FULL = main + skid entry)
//   DEF_DATA_W / DEF_CTRL_W : default payload widths
//   OCC_W        : width of the occupancy count (0..2)
//   occ_of()     : number of held instructions implied by a state
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 16;
  localparam int OCC_W      = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } pipe_state_e;

  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
    case (s)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg -- one instruction slot (control + data) with load enable
// and synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset (clears both fields)
//   i_en       : load i_ctrl/i_data at the next rising edge
//   i_clr      : clear the slot; wins over i_en. Control is always zeroed,
//                data only when CLR_DATA is set.
//   i_ctrl/i_data : payload to load
//   o_ctrl/o_data : stored payload
module pipe_entry_reg #(
  parameter int CTRL_W   = 16,
  parameter int DATA_W   = 32,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_clr) begin
      r_ctrl <= '0;
      if (CLR_DATA) r_data <= '0;
    end else if (i_en) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid -- one pipeline register stage with a skid entry so that
// in_ready is a pure register output (no combinational path from out_ready).
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous clear; held instructions become bubbles
//   in_valid/in_ready    : upstream handshake (in_ready registered)
//   in_ctrl/in_data      : upstream payload
//   out_valid/out_ready  : downstream handshake
//   out_ctrl/out_data    : presented payload (out_ctrl is zero on bubbles)
//   occupancy            : held instructions, 0..2
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CTRL_W     = DEF_CTRL_W,
  parameter int FLUSH_DATA = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_next;
  logic              r_in_ready;
  logic [OCC_W-1:0]  r_occupancy;

  logic              w_push;
  logic              w_pop;
  logic              w_main_en;
  logic              w_skid_en;
  logic              w_main_from_skid;

  logic [CTRL_W-1:0] w_main_d_ctrl;
  logic [DATA_W-1:0] w_main_d_data;
  logic [CTRL_W-1:0] w_main_q_ctrl;
  logic [DATA_W-1:0] w_main_q_data;
  logic [CTRL_W-1:0] w_skid_q_ctrl;
  logic [DATA_W-1:0] w_skid_q_data;

  assign out_valid = (r_state != ST_EMPTY);
  assign w_push    = in_valid & r_in_ready;
  assign w_pop     = out_valid & out_ready;

  // Next state and entry steering. Flush overrides any push/pop; the
  // unused encoding falls back to EMPTY.
  always_comb begin
    w_state_next     = r_state;
    w_main_en        = 1'b0;
    w_skid_en        = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_main_en    = 1'b1;
            w_state_next = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_push && w_pop) begin
            w_main_en = 1'b1;
          end else if (w_pop) begin
            w_state_next = ST_EMPTY;
          end else if (w_push) begin
            // Downstream stalled: the instruction in flight lands in skid.
            w_skid_en    = 1'b1;
            w_state_next = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_main_en        = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_next     = ST_BUSY;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // in_ready and occupancy are derived from the next state so they are
  // plain flops; in_ready stays low through reset and rises on the first
  // edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_occupancy <= '0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != ST_FULL);
      r_occupancy <= occ_of(w_state_next);
    end
  end

  assign w_main_d_ctrl = w_main_from_skid ? w_skid_q_ctrl : in_ctrl;
  assign w_main_d_data = w_main_from_skid ? w_skid_q_data : in_data;

  pipe_entry_reg #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .CLR_DATA(FLUSH_DATA != 0)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_main_en),
    .i_clr (flush),
    .i_ctrl(w_main_d_ctrl),
    .i_data(w_main_d_data),
    .o_ctrl(w_main_q_ctrl),
    .o_data(w_main_q_data)
  );

  pipe_entry_reg #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .CLR_DATA(FLUSH_DATA != 0)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_skid_en),
    .i_clr (flush),
    .i_ctrl(in_ctrl),
    .i_data(in_data),
    .o_ctrl(w_skid_q_ctrl),
    .o_data(w_skid_q_data)
  );

  assign in_ready  = r_in_ready;
  assign occupancy = r_occupancy;
  // Bubbles must decode as NOPs downstream.
  assign out_ctrl  = out_valid ? w_main_q_ctrl : '0;
  assign out_data  = w_main_q_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid -- directed scenarios plus a randomized run checked
// against a queue model of the stage (at most two held instructions, FIFO).
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int E_W    = CTRL_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of held {ctrl,data}, registered ready flag and
  // the data last held at the head (out_data keeps it when empty).
  logic [E_W-1:0]    q[$];
  bit                m_ready;
  logic [DATA_W-1:0] m_main_data;

  pipe_stage_skid #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .FLUSH_DATA(0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_ready     = 1'b0;
    m_main_data = '0;
  endtask

  // Advance one rising edge, update the model from the inputs present at
  // that edge, then move 1 time unit past it.
  task automatic tick();
    bit             push;
    bit             pop;
    logic [E_W-1:0] head;
    @(posedge clk);
    push = in_valid && m_ready;
    pop  = out_ready && (q.size() != 0);
    if (flush) begin
      q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({in_ctrl, in_data});
    end
    if (q.size() != 0) begin
      head        = q[0];
      m_main_data = head[DATA_W-1:0];
    end
    m_ready = (q.size() < 2);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b expected 0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d expected 0", occupancy); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl got %h expected 0", out_ctrl); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h expected 0", out_data); end
    @(posedge clk); #3;
    rst_n    = 1'b1;
    in_valid = 1'b1; in_ctrl = 16'h0009; in_data = 32'h99;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready got %0b expected 0", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_edge_in_ready got %0b expected 1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL first_edge_no_push occ got %0d expected 0", occupancy); end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_ctrl = 16'h0001; in_data = 32'h1234; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b expected 1", out_valid); end
    checks++; if (out_data !== 32'h1234) begin errors++; $display("FAIL basic_data got %h expected 1234", out_data); end
    checks++; if (out_ctrl !== 16'h0001) begin errors++; $display("FAIL basic_ctrl got %h expected 0001", out_ctrl); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL basic_occ got %0d expected 1", occupancy); end
    tick();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL basic_drain_occ got %0d expected 0", occupancy); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL basic_bubble_ctrl got %h expected 0", out_ctrl); end
    checks++; if (out_data !== 32'h1234) begin errors++; $display("FAIL basic_hold_data got %h expected 1234", out_data); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 16'h000A; in_data = 32'hA;
    tick();
    out_ready = 1'b0; in_ctrl = 16'h000B; in_data = 32'hB;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0b expected 0", in_ready); end
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL stall_occ got %0d expected 2", occupancy); end
    checks++; if (out_data !== 32'hA) begin errors++; $display("FAIL stall_head got %h expected A", out_data); end
    in_ctrl = 16'h000C; in_data = 32'hC;
    tick();
    checks++; if (occupancy !== 2'd2 || out_data !== 32'hA) begin errors++; $display("FAIL stall_hold occ %0d data %h expected 2 A", occupancy, out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 32'hB || occupancy !== 2'd1) begin errors++; $display("FAIL stall_second data %h occ %0d expected B 1", out_data, occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_reopen in_ready got %0b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 32'hC || out_ctrl !== 16'h000C) begin errors++; $display("FAIL stall_third data %h ctrl %h expected C 000C", out_data, out_ctrl); end
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain occ %0d valid %0b expected 0 0", occupancy, out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h0011; in_data = 32'h111;
    tick();
    in_ctrl = 16'h0022; in_data = 32'h222;
    tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_prefill occ got %0d expected 2", occupancy); end
    flush = 1'b1; in_ctrl = 16'h00FF; in_data = 32'hDEAD;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b expected 0", out_valid); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL flush_ctrl got %h expected 0", out_ctrl); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d expected 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b expected 1", in_ready); end
    checks++; if (out_data !== 32'h111) begin errors++; $display("FAIL flush_data_kept got %h expected 111", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost cycle %0d valid %0b data %h expected 0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 32'h100 + DATA_W'(i);
      in_ctrl = CTRL_W'(i + 1);
      tick();
      checks++;
      if (out_data !== 32'h100 + DATA_W'(i) || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL b2b step %0d data %h occ %0d expected %h 1", i, out_data, occupancy, 32'h100 + i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 16'h0031; in_data = 32'h31;
    tick();
    in_ctrl = 16'h0032; in_data = 32'h32;
    tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL arst_prefill occ got %0d expected 2", occupancy); end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL arst_now valid %0b occ %0d expected 0 0", out_valid, occupancy); end
    checks++; if (out_ctrl !== '0 || out_data !== '0) begin errors++; $display("FAIL arst_payload ctrl %h data %h expected 0 0", out_ctrl, out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_in_ready got %0b expected 0", in_ready); end
    @(posedge clk); #3;
    rst_n = 1'b1; in_ctrl = 16'h0077; in_data = 32'h77;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_release_ready got %0b expected 0", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || occupancy !== 2'd0) begin errors++; $display("FAIL arst_first_edge ready %0b occ %0d expected 1 0", in_ready, occupancy); end
  endtask

  task automatic test_random();
    logic [E_W-1:0]    head;
    logic [CTRL_W-1:0] exp_ctrl;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 3);
      in_ctrl   = ($urandom_range(0, 3) == 0) ? '0 : CTRL_W'($urandom);
      in_data   = DATA_W'($urandom);
      tick();
      exp_ctrl = '0;
      if (q.size() != 0) begin
        head     = q[0];
        exp_ctrl = head[E_W-1:DATA_W];
      end
      checks++; if (occupancy !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ cycle %0d got %0d expected %0d", c, occupancy, q.size()); end
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cycle %0d got %0b expected %0b", c, out_valid, q.size() != 0); end
      checks++; if (in_ready !== m_ready) begin errors++; $display("FAIL rnd_ready cycle %0d got %0b expected %0b", c, in_ready, m_ready); end
      checks++; if (out_ctrl !== exp_ctrl) begin errors++; $display("FAIL rnd_ctrl cycle %0d got %h expected %h", c, out_ctrl, exp_ctrl); end
      checks++; if (out_data !== m_main_data) begin errors++; $display("FAIL rnd_data cycle %0d got %h expected %h", c, out_data, m_main_data); end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
